imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, XLEN-parametrised immediate generator for the decode stage of the pipelined RV32I/RV64I core.
- Extracts and sign- or zero-extends the immediate from a 32-bit instruction.
- Precomputes the PC-relative target (pc + imm) for branch, JAL and AUIPC.
- Registers both results behind a valid/ready handshake with flush support.
- Sits between the fetch/decode register and the ID/EX register, replacing the single-cycle extender.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64, anything else is an elaboration error.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  discard any held result (branch mispredict/trap)
- in_valid  in  1  instr/imm_src/pc valid
- in_ready  out  1  block can accept this cycle
- instr  in  32  raw instruction
- imm_src  in  3  immediate format select
- pc  in  XLEN  instruction PC
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- imm_ext  out  XLEN  extended immediate
- tgt  out  XLEN  pc + imm_ext, modulo 2^XLEN
- bad_src  out  1  reserved imm_src was seen

Behaviour:
Formats (imm_src). Sign bit is instr[31] and is replicated to XLEN unless noted.
- 000 I: instr[31:20]
- 001 S: {instr[31:25], instr[11:7]}
- 010 B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
- 011 J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- 100 U: {instr[31:12], 12'b0}; sign-extended above bit 31 when XLEN=64
- 101 Z: CSR zimm, instr[19:15], zero-extended
- 110 SH: shamt, zero-extended; instr[24:20] for XLEN=32, instr[25:20] for XLEN=64
- 111 reserved: imm_ext=0, tgt=pc, bad_src=1. For all other codes bad_src=0.

Timing and handshake:
- Latency is 1 cycle: an input accepted at edge N appears on outputs after edge N.
- Accept occurs when in_valid && in_ready.
- When out_valid && !out_ready, imm_ext, tgt and bad_src hold stable and no new input is accepted.
- in_ready = !out_valid || out_ready (combinational path from out_ready).
- Accept and drain in the same cycle is full throughput: new data replaces old and out_valid stays 1.

Flush:
- flush=1 at an edge clears out_valid; data registers may hold stale values.
- flush overrides a simultaneous accept: that input is dropped.
- in_ready is unaffected by flush.

Reset:
- Async, active-high. Clears out_valid, imm_ext, tgt and bad_src to 0.
- in_ready reads 1 immediately while out_valid=0.
- Reset mid-transfer loses the held result; the first accept after deassertion is a normal transfer.

Arithmetic:
- tgt is an XLEN-bit add; carry out is discarded, so wrap-around is legal (e.g. pc=0, imm=-4 gives all-ones minus 3).

Optional Feature:
IMM_GEN_SKID_EN
- Defined:
  - Adds a one-entry skid register, so in_ready is a flop output equal to "skid empty", with no combinational path from out_ready.
  - When out_ready drops while an input is accepted, that input parks in the skid and in_ready falls next cycle.
  - The skid drains to the output register first, before new data.
  - flush and rst clear both the output register and the skid.
  - Throughput stays 1 per cycle, latency stays 1.
- Undefined: behaviour is exactly as in Behaviour above, with no skid storage.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_src_e (IMM_I, IMM_S, IMM_B, IMM_J, IMM_U, IMM_Z, IMM_SH, IMM_RSVD)
  - localparams XLEN_32 and XLEN_64
- Sub-module imm_decode: purely combinational (instr, imm_src) -> (imm, bad) for a given XLEN, instanced once.
- imm_gen_pipe owns the adder, handshake, flush and skid logic.

Test Plan:
1. XLEN=32, reset then I instr 0xFFF00093, pc 0x0 -> after 1 cycle out_valid=1, imm_ext=0xFFFFFFFF, tgt=0xFFFFFFFF, bad_src=0.
2. Back-to-back inputs with out_ready=1:
   - S 0xFE20AE23 -> imm_ext 0xFFFFFFFC.
   - B 0xFE000CE3 with pc 0x100 -> imm_ext 0xFFFFFFF8, tgt 0xF8.
   - J 0x0010006F with pc 0x100 -> imm_ext 0x800, tgt 0x900.
   - One result per cycle.
3. Stall: hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable and in_ready=0 (registered in skid mode after the first parked input); release -> no loss or duplication, results in order.
4. Flush: flush=1 in the same cycle as an accept of U 0x123452B7 -> out_valid=0 next cycle and that result is never emitted; the next accept emits normally.
5. XLEN=64: U 0x800002B7 -> imm_ext 0xFFFFFFFF80000000; SH with instr[25:20]=0x3F -> 63; Z with instr[19:15]=0x1F -> 31.
6. imm_src=111 with pc 0x40 -> imm_ext 0, tgt 0x40, bad_src=1. Also assert rst while out_valid=1 -> all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/imm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_pkg                                                              |
// | Shared immediate-format encodings and supported datapath widths.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I    = 3'b000,
    IMM_S    = 3'b001,
    IMM_B    = 3'b010,
    IMM_J    = 3'b011,
    IMM_U    = 3'b100,
    IMM_Z    = 3'b101,
    IMM_SH   = 3'b110,
    IMM_RSVD = 3'b111
  } imm_src_e;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

endpackage
`default_nettype wire

// File: rtl/imm_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_decode                                                           |
// | Combinational immediate extraction and sign/zero extension.          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imm_decode
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic [XLEN-1:0] imm,
  output logic            bad
);

  if (XLEN != XLEN_32 && XLEN != XLEN_64) begin : g_bad_xlen
    $error("imm_decode: XLEN must be 32 or 64");
  end

  // Opcode bits never contribute to an immediate.
  logic w_unused;
  assign w_unused = ^instr[6:0];

  always_comb begin
    imm = '0;
    bad = 1'b0;
    case (imm_src_e'(imm_src))
      IMM_I:    imm = XLEN'($signed(instr[31:20]));
      IMM_S:    imm = XLEN'($signed({instr[31:25], instr[11:7]}));
      IMM_B:    imm = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      IMM_J:    imm = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      IMM_U:    imm = XLEN'($signed({instr[31:12], 12'b0}));
      IMM_Z:    imm = XLEN'(instr[19:15]);
      IMM_SH:   imm = (XLEN == XLEN_64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      IMM_RSVD: bad = 1'b1;
      default:  bad = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | imm_gen_pipe                                                         |
// | Registered immediate generator with pc+imm target and handshake.     |
// | Optional macro IMM_GEN_SKID_EN adds a one-entry skid buffer.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] tgt,
  output logic            bad_src
);

  logic [XLEN-1:0] w_imm;
  logic [XLEN-1:0] w_tgt;
  logic            w_bad;
  logic            w_accept;

  logic            r_out_valid;
  logic [XLEN-1:0] r_imm;
  logic [XLEN-1:0] r_tgt;
  logic            r_bad;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (instr),
    .imm_src (imm_src),
    .imm     (w_imm),
    .bad     (w_bad)
  );

  // Reserved codes decode to imm=0, so the target naturally falls back to pc.
  assign w_tgt    = pc + w_imm;
  assign w_accept = in_valid && in_ready;

`ifdef IMM_GEN_SKID_EN
  logic            r_skid_valid;
  logic [XLEN-1:0] r_skid_imm;
  logic [XLEN-1:0] r_skid_tgt;
  logic            r_skid_bad;
  logic            w_out_free;

  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = !r_skid_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_imm        <= '0;
      r_tgt        <= '0;
      r_bad        <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_imm   <= '0;
      r_skid_tgt   <= '0;
      r_skid_bad   <= 1'b0;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_out_free) begin
      // A parked entry always goes out ahead of anything new; in_ready is low then.
      if (r_skid_valid) begin
        r_imm        <= r_skid_imm;
        r_tgt        <= r_skid_tgt;
        r_bad        <= r_skid_bad;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_imm       <= w_imm;
        r_tgt       <= w_tgt;
        r_bad       <= w_bad;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_imm   <= w_imm;
      r_skid_tgt   <= w_tgt;
      r_skid_bad   <= w_bad;
      r_skid_valid <= 1'b1;
    end
  end
`else
  assign in_ready = !r_out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_imm       <= '0;
      r_tgt       <= '0;
      r_bad       <= 1'b0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      if (w_accept && !flush) begin
        r_imm <= w_imm;
        r_tgt <= w_tgt;
        r_bad <= w_bad;
      end
    end
  end
`endif

  assign out_valid = r_out_valid;
  assign imm_ext   = r_imm;
  assign tgt       = r_tgt;
  assign bad_src   = r_bad;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_imm_gen_pipe                                                      |
// | Directed and random checks of imm_gen_pipe at XLEN=32 and XLEN=64.   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_imm_gen_pipe;

  logic clk;
  logic rst;

  logic        flush, in_valid, in_ready, out_valid, out_ready, bad_src;
  logic [31:0] instr, pc, imm_ext, tgt;
  logic [2:0]  imm_src;

  logic        flush64, in_valid64, in_ready64, out_valid64, out_ready64, bad_src64;
  logic [31:0] instr64;
  logic [63:0] pc64, imm_ext64, tgt64;
  logic [2:0]  imm_src64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] imm;
    logic [63:0] tgt;
    logic        bad;
  } res_t;

  res_t q[$];

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .imm_src(imm_src), .pc(pc), .out_valid(out_valid),
    .out_ready(out_ready), .imm_ext(imm_ext), .tgt(tgt), .bad_src(bad_src)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64), .in_valid(in_valid64), .in_ready(in_ready64),
    .instr(instr64), .imm_src(imm_src64), .pc(pc64), .out_valid(out_valid64),
    .out_ready(out_ready64), .imm_ext(imm_ext64), .tgt(tgt64), .bad_src(bad_src64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Immediate value as a signed integer, built from field weights, then truncated.
  function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] src,
                                          input int xlen);
    longint v;
    v = 0;
    case (src)
      3'd0: begin v = ins[31:20]; if (ins[31]) v -= 4096; end
      3'd1: begin v = {ins[31:25], ins[11:7]}; if (ins[31]) v -= 4096; end
      3'd2: begin v = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; if (ins[31]) v -= 8192; end
      3'd3: begin v = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; if (ins[31]) v -= 2097152; end
      3'd4: begin v = longint'(ins[31:12]) * 4096; if (ins[31]) v -= 64'h1_0000_0000; end
      3'd5: v = ins[19:15];
      3'd6: v = (xlen == 64) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      default: v = 0;
    endcase
    if (xlen == 32) return {32'b0, v[31:0]};
    return v;
  endfunction

  // One clock of the 32-bit DUT, against a queue of results still owed downstream.
  task automatic step32(input logic v, input logic [31:0] ins, input logic [2:0] src,
                        input logic [31:0] p, input logic ordy, input logic fl);
    logic        exp_ready;
    logic        acc;
    logic [31:0] t;
    res_t        r;
    in_valid = v; instr = ins; imm_src = src; pc = p; out_ready = ordy; flush = fl;
    #1;
    exp_ready = (q.size() == 0) || ordy;
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    if (q.size() > 0 && ordy) void'(q.pop_front());
    if (fl) q.delete();
    else if (acc) begin
      r.imm = ref_imm(ins, src, 32);
      t     = p + r.imm[31:0];
      r.tgt = {32'b0, t};
      r.bad = (src == 3'd7);
      q.push_back(r);
    end
    #1;
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("imm_ext", 64'(imm_ext), q[0].imm);
      check("tgt", 64'(tgt), q[0].tgt);
      check("bad_src", 64'(bad_src), 64'(q[0].bad));
    end
  endtask

  task automatic step64(input logic [31:0] ins, input logic [2:0] src, input logic [63:0] p);
    logic [63:0] ei;
    in_valid64 = 1'b1; instr64 = ins; imm_src64 = src; pc64 = p; out_ready64 = 1'b1;
    ei = ref_imm(ins, src, 64);
    @(posedge clk);
    #1;
    in_valid64 = 1'b0;
    check("out_valid64", 64'(out_valid64), 64'd1);
    check("imm_ext64", imm_ext64, ei);
    check("tgt64", tgt64, p + ei);
    check("bad_src64", 64'(bad_src64), 64'(src == 3'd7));
  endtask

  initial begin
    rst = 1'b1;
    flush = 0; in_valid = 0; instr = '0; imm_src = '0; pc = '0; out_ready = 0;
    flush64 = 0; in_valid64 = 0; instr64 = '0; imm_src64 = '0; pc64 = '0; out_ready64 = 1;
    @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_imm_ext", 64'(imm_ext), 64'd0);
    check("rst_tgt", 64'(tgt), 64'd0);
    check("rst_bad_src", 64'(bad_src), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst = 1'b0;

    // I-type with pc 0
    step32(1, 32'hFFF00093, 3'd0, 32'h0, 1, 0);
    check("plan1_imm", 64'(imm_ext), 64'hFFFFFFFF);
    check("plan1_tgt", 64'(tgt), 64'hFFFFFFFF);

    // Back-to-back S, B, J
    step32(1, 32'hFE20AE23, 3'd1, 32'h0, 1, 0);
    check("plan2_s_imm", 64'(imm_ext), 64'hFFFFFFFC);
    step32(1, 32'hFE000CE3, 3'd2, 32'h100, 1, 0);
    check("plan2_b_tgt", 64'(tgt), 64'hF8);
    step32(1, 32'h0010006F, 3'd3, 32'h100, 1, 0);
    check("plan2_j_imm", 64'(imm_ext), 64'h800);
    check("plan2_j_tgt", 64'(tgt), 64'h900);

    // Stall for three cycles with input pending, then release
    step32(1, 32'h00500113, 3'd0, 32'h10, 0, 0);
    step32(1, 32'h00600113, 3'd0, 32'h20, 0, 0);
    step32(1, 32'h00700113, 3'd0, 32'h30, 0, 0);
    step32(1, 32'h00800113, 3'd0, 32'h40, 1, 0);
    step32(0, 32'h0, 3'd0, 32'h0, 1, 0);

    // Flush drops a simultaneous accept
    step32(1, 32'h123452B7, 3'd4, 32'h0, 1, 1);
    check("plan4_flushed", 64'(out_valid), 64'd0);
    step32(1, 32'h123452B7, 3'd4, 32'h4, 1, 0);
    check("plan4_after", 64'(imm_ext), 64'h12345000);

    // Reserved code
    step32(1, 32'hFFFFFFFF, 3'd7, 32'h40, 1, 0);
    check("plan6_imm", 64'(imm_ext), 64'h0);
    check("plan6_tgt", 64'(tgt), 64'h40);
    check("plan6_bad", 64'(bad_src), 64'd1);

    // Asynchronous reset while a result is held
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_imm_ext", 64'(imm_ext), 64'd0);
    check("arst_tgt", 64'(tgt), 64'd0);
    check("arst_bad_src", 64'(bad_src), 64'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step32(1, 32'hFFC00093, 3'd0, 32'h8, 1, 0);
    step32(0, 32'h0, 3'd0, 32'h0, 1, 0);

    // XLEN=64 directed
    step64(32'h800002B7, 3'd4, 64'h0);
    check("plan5_u64", imm_ext64, 64'hFFFFFFFF80000000);
    step64(32'h03F00013, 3'd6, 64'h1000);
    check("plan5_sh64", imm_ext64, 64'd63);
    step64(32'h000F8073, 3'd5, 64'h0);
    check("plan5_z64", imm_ext64, 64'd31);
    step64(32'hFFC00093, 3'd0, 64'h0);
    check("wrap64", tgt64, 64'hFFFFFFFFFFFFFFFC);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step32($urandom_range(0, 3) != 0, $urandom, 3'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
    end
    for (int i = 0; i < 40; i++) begin
      step64($urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
